transpose_sched: RTL and testbench
==================================

TRANSPOSE_SCHED -- requirements
Module: transpose_sched

Interface
REQ-001 Parameter ADDR_W, default 8, shared-memory address width.
REQ-002 Parameter DATA_W, default 32, shared-memory data width.
REQ-003 Parameter N_WORDS, default 256, kernel writes per job (16x16 transpose).
REQ-004 Parameter TIMEOUT, default 1024, max RUN cycles before error.
REQ-005 Ports SHALL be (name direction width meaning):
- clk  in  1  single clock, all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- launch_valid  in  1  host requests a job
- launch_ready  out  1  scheduler accepts a job
- tstart  out  1  one-cycle kernel start pulse
- k_rd_en  in  1  kernel read enable (kernel v0 port)
- k_addr  in  ADDR_W  kernel read address
- k_wr_en  in  1  kernel write strobe (v1 port, monitored only)
- h_rd_req  in  1  host read request
- h_addr  in  ADDR_W  host read address
- h_rd_gnt  out  1  host request granted this cycle
- h_rd_valid  out  1  host read data valid
- h_rd_data  out  DATA_W  host read data
- mem_rd_en  out  1  shared memory read enable
- mem_addr  out  ADDR_W  shared memory address
- mem_rd_data  in  DATA_W  memory data, valid one cycle after mem_rd_en
- busy  out  1  job in progress
- done  out  1  one-cycle job-complete pulse
- err  out  1  one-cycle timeout pulse
- job_cnt  out  16  completed-job count

Function
REQ-006 FSM states SHALL be IDLE, LAUNCH, RUN, DONE, ERR.
REQ-007 launch_ready = 1 only in IDLE; launch_valid & launch_ready SHALL move to LAUNCH next cycle.
REQ-008 LAUNCH: tstart = 1 exactly one cycle, then RUN; tstart = 0 in all other states.
REQ-009 RUN: wr_cnt (width clog2(N_WORDS)+1) increments per k_wr_en cycle; tmo_cnt increments every cycle.
REQ-010 RUN: k_wr_en with wr_cnt == N_WORDS-1 SHALL go to DONE; else tmo_cnt == TIMEOUT-1 SHALL go to ERR.
REQ-011 Final write and timeout in same cycle: DONE wins.
REQ-012 DONE: done = 1 one cycle, job_cnt += 1 (wraps 0xFFFF -> 0), then IDLE.
REQ-013 ERR: err = 1 one cycle, job_cnt unchanged, then IDLE.
REQ-014 wr_cnt and tmo_cnt SHALL clear on LAUNCH entry; k_wr_en outside RUN ignored.
REQ-015 busy = 1 in LAUNCH and RUN, 0 otherwise.
REQ-016 Arbiter: kernel has absolute priority; k_rd_en = 1 drives mem_rd_en = 1, mem_addr = k_addr, in any state.
REQ-017 h_rd_gnt = h_rd_req & ~k_rd_en (combinational); grant drives mem_rd_en = 1, mem_addr = h_addr.
REQ-018 Host request denied SHALL be held by host; no internal queueing.
REQ-019 h_rd_valid = registered h_rd_gnt (1-cycle latency); h_rd_data = mem_rd_data when h_rd_valid, else 0.
REQ-020 No request: mem_rd_en = 0, mem_addr = 0.
REQ-021 Kernel read data SHALL be wired memory-to-kernel externally; block adds no kernel-path latency.

Reset
REQ-022 rst asserted SHALL immediately force IDLE, counters 0, job_cnt 0, and tstart, done, err, busy, h_rd_valid to 0.
REQ-023 rst during RUN SHALL abort the job with no done/err pulse; launch_ready = 1 first cycle after release.

Verification
REQ-024 Reset release, launch_valid = 1 one cycle -> launch_ready 1, tstart at cycle+1, busy cycles +1..+2 and through RUN.
REQ-025 Kernel model: 256 k_wr_en pulses in RUN -> done 1 cycle after 256th write, job_cnt 0 -> 1, busy 0.
REQ-026 Only 100 writes, TIMEOUT = 1024 -> err on cycle 1024 of RUN, job_cnt unchanged, IDLE.
REQ-027 h_rd_req with addr 0x05 and k_rd_en with addr 0x10 same cycle -> mem_addr 0x10, h_rd_gnt 0; next cycle k_rd_en 0 -> gnt 1, mem_addr 0x05, h_rd_valid 1 cycle later with mem_rd_data.
REQ-028 Last write coincident with tmo_cnt == TIMEOUT-1 -> done 1, err 0.
REQ-029 rst after 50 writes in RUN -> no done/err, wr_cnt 0; new launch requires full 256 writes.

Source files
------------

// File: rtl/transpose_sched.sv
// -----------------------------------------------------------------------------
// transpose_sched
//
// This block runs transpose jobs and shares one read port between a kernel and
// a host.
//   * A small FSM (IDLE -> LAUNCH -> RUN -> DONE/ERR -> IDLE) accepts a job,
//     sends the kernel a one-cycle start pulse, and counts kernel writes until
//     N_WORDS have been seen. If that does not happen within TIMEOUT RUN
//     cycles, the job is aborted with an error pulse.
//   * A fixed-priority arbiter gives the shared memory read port to the kernel
//     whenever it asks. Otherwise the port goes to the host. Host read data
//     comes back one cycle after the grant.
//
// Ports
//   clk, rst          clock; asynchronous active-high reset
//   launch_valid/_ready  job request handshake (ready only in IDLE)
//   tstart            one-cycle kernel start pulse (LAUNCH state)
//   k_rd_en, k_addr   kernel read request (highest priority)
//   k_wr_en           kernel write strobe, monitored to count job progress
//   h_rd_req, h_addr  host read request; host holds it until granted
//   h_rd_gnt          host granted this cycle (combinational)
//   h_rd_valid/_data  host read return, one cycle after the grant
//   mem_rd_en, mem_addr, mem_rd_data  shared memory read port (1-cycle data)
//   busy, done, err   job status; done/err are one-cycle pulses
//   job_cnt           count of completed jobs (wraps at 16 bits)
// -----------------------------------------------------------------------------
module transpose_sched #(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 32,
  parameter int N_WORDS = 256,
  parameter int TIMEOUT = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              launch_valid,
  output logic              launch_ready,
  output logic              tstart,
  input  logic              k_rd_en,
  input  logic [ADDR_W-1:0] k_addr,
  input  logic              k_wr_en,
  input  logic              h_rd_req,
  input  logic [ADDR_W-1:0] h_addr,
  output logic              h_rd_gnt,
  output logic              h_rd_valid,
  output logic [DATA_W-1:0] h_rd_data,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rd_data,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [15:0]       job_cnt
);

  localparam int WR_W  = $clog2(N_WORDS) + 1;
  localparam int TMO_W = $clog2(TIMEOUT) + 1;
  localparam logic [WR_W-1:0]  WR_LAST  = WR_W'(N_WORDS - 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE,
    LAUNCH,
    RUN,
    DONE,
    ERR
  } state_t;

  state_t            state_reg, state_next;
  logic [WR_W-1:0]   wr_cnt_reg;
  logic [TMO_W-1:0]  tmo_cnt_reg;
  logic [15:0]       job_cnt_reg;
  logic              h_rd_valid_reg;

  // ---------------------------------------------------------------------------
  // Job FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:   if (launch_valid) state_next = LAUNCH;
      LAUNCH: state_next = RUN;
      RUN: begin
        // The final write takes priority over a timeout in the same cycle.
        if (k_wr_en && (wr_cnt_reg == WR_LAST)) begin
          state_next = DONE;
        end else if (tmo_cnt_reg == TMO_LAST) begin
          state_next = ERR;
        end
      end
      DONE:   state_next = IDLE;
      ERR:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign launch_ready = (state_reg == IDLE);
  assign tstart       = (state_reg == LAUNCH);
  assign busy         = (state_reg == LAUNCH) || (state_reg == RUN);
  assign done         = (state_reg == DONE);
  assign err          = (state_reg == ERR);

  // ---------------------------------------------------------------------------
  // Progress / timeout / job counters
  // ---------------------------------------------------------------------------
  // The counters are cleared for the whole LAUNCH cycle, so RUN always starts
  // from zero. Kernel writes seen before RUN therefore have no effect.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_cnt_reg  <= '0;
      tmo_cnt_reg <= '0;
      job_cnt_reg <= '0;
    end else begin
      case (state_reg)
        LAUNCH: begin
          wr_cnt_reg  <= '0;
          tmo_cnt_reg <= '0;
        end
        RUN: begin
          tmo_cnt_reg <= tmo_cnt_reg + 1'b1;
          if (k_wr_en) begin
            wr_cnt_reg <= wr_cnt_reg + 1'b1;
          end
        end
        DONE: begin
          job_cnt_reg <= job_cnt_reg + 16'd1;  // natural 16-bit wrap
        end
        default: ;
      endcase
    end
  end

  assign job_cnt = job_cnt_reg;

  // ---------------------------------------------------------------------------
  // Read-port arbiter: the kernel always wins, and the host gets leftover cycles
  // ---------------------------------------------------------------------------
  assign h_rd_gnt = h_rd_req & ~k_rd_en;

  always_comb begin
    mem_rd_en = 1'b0;
    mem_addr  = '0;
    if (k_rd_en) begin
      mem_rd_en = 1'b1;
      mem_addr  = k_addr;
    end else if (h_rd_req) begin
      mem_rd_en = 1'b1;
      mem_addr  = h_addr;
    end
  end

  // Memory data arrives one cycle after the enable. A registered copy of the
  // grant therefore marks the cycle in which the host's data is on the bus.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h_rd_valid_reg <= 1'b0;
    end else begin
      h_rd_valid_reg <= h_rd_gnt;
    end
  end

  assign h_rd_valid = h_rd_valid_reg;
  assign h_rd_data  = h_rd_valid_reg ? mem_rd_data : '0;

endmodule

// File: tb/tb_transpose_sched.sv
// -----------------------------------------------------------------------------
// tb_transpose_sched
// Self-checking bench for transpose_sched with default parameters.
// The job FSM is driven by directed kernel write sequences.
// Host reads are checked by a scoreboard: when a grant is expected, the
// expected data and its due cycle are pushed to a queue. A negedge monitor
// pops the queue and compares whenever h_rd_valid appears.
// -----------------------------------------------------------------------------
module tb_transpose_sched;

  localparam int ADDR_W  = 8;
  localparam int DATA_W  = 32;
  localparam int N_WORDS = 256;
  localparam int TIMEOUT = 1024;

  logic              clk = 1'b0;
  logic              rst;
  logic              launch_valid;
  logic              launch_ready;
  logic              tstart;
  logic              k_rd_en;
  logic [ADDR_W-1:0] k_addr;
  logic              k_wr_en;
  logic              h_rd_req;
  logic [ADDR_W-1:0] h_addr;
  logic              h_rd_gnt;
  logic              h_rd_valid;
  logic [DATA_W-1:0] h_rd_data;
  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_rd_data;
  logic              busy;
  logic              done;
  logic              err;
  logic [15:0]       job_cnt;

  transpose_sched #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .N_WORDS(N_WORDS),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .launch_valid(launch_valid),
    .launch_ready(launch_ready),
    .tstart      (tstart),
    .k_rd_en     (k_rd_en),
    .k_addr      (k_addr),
    .k_wr_en     (k_wr_en),
    .h_rd_req    (h_rd_req),
    .h_addr      (h_addr),
    .h_rd_gnt    (h_rd_gnt),
    .h_rd_valid  (h_rd_valid),
    .h_rd_data   (h_rd_data),
    .mem_rd_en   (mem_rd_en),
    .mem_addr    (mem_addr),
    .mem_rd_data (mem_rd_data),
    .busy        (busy),
    .done        (done),
    .err         (err),
    .job_cnt     (job_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  typedef struct {
    logic [DATA_W-1:0] data;
    int                due;
  } exp_t;
  exp_t sb_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // The memory contents are a fixed function of the address.
  function automatic logic [DATA_W-1:0] mem_fn(input logic [ADDR_W-1:0] a);
    return {8'hC3, a, ~a, a ^ 8'h5A};
  endfunction

  always @(posedge clk) begin
    cyc <= cyc + 1;
    mem_rd_data <= mem_rd_en ? mem_fn(mem_addr) : 32'hDEAD_BEEF;
  end

  // Host-return monitor
  always @(negedge clk) begin
    if (!rst) begin
      if (h_rd_valid) begin
        if (sb_q.size() == 0) begin
          check("unexpected_h_rd_valid", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          check("h_rd_data", h_rd_data, e.data);
          check("h_rd_latency", cyc, e.due);
          $display("host read: data=0x%08h cycle=%0d", h_rd_data, cyc);
        end
      end else begin
        check("h_rd_data_idle_zero", h_rd_data, 32'd0);
        if (sb_q.size() != 0 && sb_q[0].due <= cyc) begin
          check("h_rd_valid_missing", 32'd0, 32'd1);
          void'(sb_q.pop_front());
        end
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Request a job in IDLE. Optionally hold k_wr_en high during the handshake
  // and LAUNCH cycles, where it must be ignored. The task returns one step into
  // the first RUN cycle.
  task automatic do_launch(input bit wr_noise);
    launch_valid = 1'b1;
    k_wr_en      = wr_noise;
    @(negedge clk);
    check("launch_ready_idle", launch_ready, 1'b1);
    check("tstart_idle", tstart, 1'b0);
    tick();
    launch_valid = 1'b0;
    @(negedge clk);
    check("tstart_launch", tstart, 1'b1);
    check("busy_launch", busy, 1'b1);
    check("launch_ready_launch", launch_ready, 1'b0);
    tick();
    k_wr_en = 1'b0;
  endtask

  // Run RUN_CYCLES cycles of RUN. Writes occur on cycles 1..n_first and,
  // optionally, on the last cycle. At the end, check which pulse appears.
  task automatic run_job(input int run_cycles, input int n_first, input bit last_wr,
                         input bit exp_done, input logic [15:0] exp_job_cnt);
    for (int c = 1; c <= run_cycles; c++) begin
      k_wr_en = (c <= n_first) || (last_wr && c == run_cycles);
      @(negedge clk);
      if (c == 1) check("tstart_run", tstart, 1'b0);
      if (c == run_cycles) begin
        check("busy_run_last", busy, 1'b1);
        check("done_before_end", done, 1'b0);
        check("err_before_end", err, 1'b0);
      end
      tick();
    end
    k_wr_en = 1'b0;
    @(negedge clk);
    check("done_pulse", done, exp_done);
    check("err_pulse", err, !exp_done);
    check("busy_end", busy, 1'b0);
    tick();
    @(negedge clk);
    check("done_clear", done, 1'b0);
    check("err_clear", err, 1'b0);
    check("job_cnt", job_cnt, exp_job_cnt);
    check("launch_ready_back", launch_ready, 1'b1);
    $display("job end: done=%0b job_cnt=%0d cycle=%0d", exp_done, job_cnt, cyc);
    tick();
  endtask

  task automatic arb_cycle(input bit hreq, input logic [ADDR_W-1:0] ha,
                           input bit kreq, input logic [ADDR_W-1:0] ka);
    bit                exp_gnt;
    logic [ADDR_W-1:0] exp_addr;
    h_rd_req = hreq;
    h_addr   = ha;
    k_rd_en  = kreq;
    k_addr   = ka;
    exp_gnt  = hreq && !kreq;
    exp_addr = kreq ? ka : (hreq ? ha : '0);
    @(negedge clk);
    check("h_rd_gnt", h_rd_gnt, exp_gnt);
    check("mem_rd_en", mem_rd_en, hreq | kreq);
    check("mem_addr", mem_addr, exp_addr);
    if (exp_gnt) begin
      exp_t e;
      e.data = mem_fn(ha);
      e.due  = cyc + 1;
      sb_q.push_back(e);
    end
    $display("arb: hreq=%0b ha=0x%02h kreq=%0b ka=0x%02h gnt=%0b mem_addr=0x%02h",
             hreq, ha, kreq, ka, h_rd_gnt, mem_addr);
    tick();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    launch_valid = 1'b0;
    k_rd_en = 1'b0;
    k_addr = '0;
    k_wr_en = 1'b0;
    h_rd_req = 1'b0;
    h_addr = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", busy, 1'b0);
    check("rst_tstart", tstart, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_err", err, 1'b0);
    check("rst_job_cnt", job_cnt, 16'd0);
    check("rst_h_rd_valid", h_rd_valid, 1'b0);
    check("rst_mem_rd_en", mem_rd_en, 1'b0);
    check("rst_mem_addr", mem_addr, 8'h00);
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("launch_ready_after_rst", launch_ready, 1'b1);
    tick();

    // Job 1: 256 writes (with k_wr_en noise during launch) -> done.
    do_launch(1'b1);
    run_job(N_WORDS, N_WORDS, 1'b0, 1'b1, 16'd1);

    // Job 2: only 100 writes -> timeout on RUN cycle 1024.
    do_launch(1'b0);
    run_job(TIMEOUT, 100, 1'b0, 1'b0, 16'd1);

    // Job 3: the last write lands exactly on the timeout cycle -> done wins.
    do_launch(1'b0);
    run_job(TIMEOUT, N_WORDS - 1, 1'b1, 1'b1, 16'd2);

    // Job 4: reset after 50 writes aborts the job without a pulse.
    do_launch(1'b0);
    for (int c = 0; c < 50; c++) begin
      k_wr_en = 1'b1;
      tick();
    end
    k_wr_en = 1'b0;
    rst = 1'b1;
    #1;
    check("abort_busy", busy, 1'b0);
    check("abort_job_cnt", job_cnt, 16'd0);
    check("abort_launch_ready", launch_ready, 1'b1);
    @(negedge clk);
    check("abort_done", done, 1'b0);
    check("abort_err", err, 1'b0);
    tick();
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("abort_ready_after_release", launch_ready, 1'b1);
    check("abort_done_after", done, 1'b0);
    check("abort_err_after", err, 1'b0);
    $display("job abort: reset after 50 writes cycle=%0d", cyc);
    tick();

    // Job 5: after the abort, a full 256 writes are needed again.
    do_launch(1'b0);
    run_job(N_WORDS, N_WORDS, 1'b0, 1'b1, 16'd1);

    // Arbiter: the kernel wins first; the host is granted once the kernel
    // drops its request.
    arb_cycle(1'b1, 8'h05, 1'b1, 8'h10);
    arb_cycle(1'b1, 8'h05, 1'b0, 8'h00);
    arb_cycle(1'b0, 8'h00, 1'b0, 8'h00);
    for (int i = 0; i < 30; i++) begin
      arb_cycle(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)),
                1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)));
    end
    arb_cycle(1'b0, 8'h00, 1'b0, 8'h00);
    repeat (3) tick();
    check("scoreboard_drained", sb_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
